// File: rtl/elev_delay_timer_pkg.sv
// Shared types and constants for the elevator delay timers.
// One package serves every timed function in the controller.
package elev_timer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } timer_state_t;

    localparam int CLK_HZ_50M = 50_000_000;

    // Next state after a (re)load of the seconds counter.
    function automatic timer_state_t load_state(input logic zero);
        return zero ? DONE : COUNT;
    endfunction

endpackage

// File: rtl/elev_delay_timer_if.sv
// Control/status bundle between the elevator FSM and one timer.
// The FSM side is master, the timer side is slave.
interface elev_delay_timer_if #(
    parameter int SEC_W = 4
);
    logic             enable;
    logic [SEC_W-1:0] delay_sec;
    logic             hold;
    logic             restart;
    logic             done;
    logic             done_pulse;
    logic             busy;
    logic [SEC_W-1:0] remaining_sec;

    modport master (
        output enable,
        output delay_sec,
        output hold,
        output restart,
        input  done,
        input  done_pulse,
        input  busy,
        input  remaining_sec
    );

    modport slave (
        input  enable,
        input  delay_sec,
        input  hold,
        input  restart,
        output done,
        output done_pulse,
        output busy,
        output remaining_sec
    );
endinterface

// File: rtl/elev_delay_timer_prescaler.sv
// Divides clk_50M down to a one-cycle tick per second.
// clr wins over run; tick fires on the last cycle of a second.
module elev_sec_prescaler #(
    parameter int CLK_HZ = elev_timer_pkg::CLK_HZ_50M
) (
    input  logic clk_50M,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic tick
);
    localparam int PRESC_W = $clog2(CLK_HZ);
    localparam logic [PRESC_W-1:0] LAST = PRESC_W'(CLK_HZ - 1);

    logic [PRESC_W-1:0] cnt_q;
    logic [PRESC_W-1:0] cnt_d;

    // Count up while running, wrap at the end of each second.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + PRESC_W'(1);
            end
        end
    end

    // Prescaler register.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = run && !clr && (cnt_q == LAST);

endmodule

// File: rtl/elev_delay_timer.sv
// Seconds-resolution delay timer with hold, restart and done strobe.
// FSM plus seconds down-counter; all outputs come from flops.
module elev_delay_timer
    import elev_timer_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_50M,
    parameter int SEC_W  = 4
) (
    input  logic clk_50M,
    input  logic rst_n,
    elev_delay_timer_if.slave tmr
);
    timer_state_t     state_q;
    timer_state_t     state_d;
    logic [SEC_W-1:0] rem_q;
    logic [SEC_W-1:0] rem_d;

    logic done_q;
    logic done_d;
    logic pulse_q;
    logic pulse_d;
    logic busy_q;
    logic busy_d;

    logic tick;
    logic presc_clr;
    logic presc_run;
    logic dly_zero;

    assign dly_zero  = (tmr.delay_sec == '0);
    assign presc_run = (state_q == COUNT) && !tmr.hold;
    assign presc_clr = !tmr.enable || tmr.restart
                       || (state_q != COUNT);

    elev_sec_prescaler #(
        .CLK_HZ (CLK_HZ)
    ) u_presc (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .clr     (presc_clr),
        .run     (presc_run),
        .tick    (tick)
    );

    // State and seconds counter registers.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Next state: enable low aborts, then restart, then hold, then tick.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (!tmr.enable) begin
            state_d = IDLE;
            rem_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    rem_d   = tmr.delay_sec;
                    state_d = load_state(dly_zero);
                end
                COUNT: begin
                    if (tmr.restart) begin
                        rem_d   = tmr.delay_sec;
                        state_d = load_state(dly_zero);
                    end else if (tmr.hold) begin
                        rem_d = rem_q;
                    end else if (tick) begin
                        if (rem_q == SEC_W'(1)) begin
                            rem_d   = '0;
                            state_d = DONE;
                        end else begin
                            rem_d = rem_q - SEC_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (tmr.restart) begin
                        rem_d   = tmr.delay_sec;
                        state_d = load_state(dly_zero);
                    end
                end
                default: begin
                    state_d = IDLE;
                    rem_d   = '0;
                end
            endcase
        end
    end

    // Outputs follow the next state; a pulse marks every fresh entry to DONE.
    always_comb begin
        done_d  = (state_d == DONE);
        busy_d  = (state_d == COUNT);
        pulse_d = (state_d == DONE)
                  && ((state_q != DONE) || tmr.restart);
    end

    // Output registers.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            done_q  <= 1'b0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q  <= done_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
        end
    end

    assign tmr.done          = done_q;
    assign tmr.done_pulse    = pulse_q;
    assign tmr.busy          = busy_q;
    assign tmr.remaining_sec = rem_q;

endmodule

// File: tb/tb_elev_delay_timer.sv
// Directed bench for elev_delay_timer at CLK_HZ=10, SEC_W=4.
// Expected values are counted by hand from the sampling edge.
module tb_elev_delay_timer;

    localparam int CLK_HZ = 10;
    localparam int SEC_W  = 4;

    logic clk_50M = 1'b0;
    logic rst_n   = 1'b0;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int p0;

    elev_delay_timer_if #(.SEC_W(SEC_W)) u_if ();

    elev_delay_timer #(
        .CLK_HZ (CLK_HZ),
        .SEC_W  (SEC_W)
    ) u_dut (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .tmr     (u_if.slave)
    );

    always #5 clk_50M = ~clk_50M;

    always @(negedge clk_50M) begin
        if (u_if.done_pulse) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_50M);
            #1;
        end
    endtask

    task automatic outs(input string tag, input int d, input int p,
                        input int b, input int r);
        chk({tag, ".done"}, int'(u_if.done), d);
        chk({tag, ".pulse"}, int'(u_if.done_pulse), p);
        chk({tag, ".busy"}, int'(u_if.busy), b);
        chk({tag, ".rem"}, int'(u_if.remaining_sec), r);
    endtask

    task automatic go(input int dly);
        u_if.enable = 1'b0;
        step();
        u_if.delay_sec = SEC_W'(dly);
        u_if.enable    = 1'b1;
        step();
    endtask

    initial begin
        u_if.enable    = 1'b0;
        u_if.delay_sec = '0;
        u_if.hold      = 1'b0;
        u_if.restart   = 1'b0;
        #1;
        outs("rst", 0, 0, 0, 0);
        step(2);
        rst_n = 1'b1;
        step();
        outs("idle", 0, 0, 0, 0);

        // Reset asserted mid-count.
        go(5);
        step(3);
        rst_n = 1'b0;
        #1;
        outs("rstmid", 0, 0, 0, 0);
        u_if.enable = 1'b0;
        p0 = pulse_cnt;
        step(2);
        rst_n = 1'b1;
        step(5);
        outs("rstrel", 0, 0, 0, 0);
        chk("rstrel.npulse", pulse_cnt - p0, 0);

        // Plain 3 s count.
        p0 = pulse_cnt;
        go(3);
        outs("c3.s", 0, 0, 1, 3);
        step(9);
        chk("c3.s9.rem", int'(u_if.remaining_sec), 3);
        step();
        chk("c3.s10.rem", int'(u_if.remaining_sec), 2);
        step(10);
        chk("c3.s20.rem", int'(u_if.remaining_sec), 1);
        step(9);
        outs("c3.s29", 0, 0, 1, 1);
        step();
        outs("c3.s30", 1, 1, 0, 0);
        step();
        outs("c3.s31", 1, 0, 0, 0);
        step(5);
        chk("c3.hold.done", int'(u_if.done), 1);
        chk("c3.npulse", pulse_cnt - p0, 1);
        u_if.enable = 1'b0;
        step();
        outs("c3.off", 0, 0, 0, 0);

        // 2 s count with a 7-cycle hold.
        go(2);
        step(5);
        u_if.hold = 1'b1;
        step(7);
        outs("hld.in", 0, 0, 1, 2);
        u_if.hold = 1'b0;
        step(4);
        chk("hld.s16.rem", int'(u_if.remaining_sec), 2);
        step();
        chk("hld.s17.rem", int'(u_if.remaining_sec), 1);
        step(9);
        chk("hld.s26.done", int'(u_if.done), 0);
        step();
        outs("hld.s27", 1, 1, 0, 0);

        // Restart mid-count with a new delay, then again from DONE.
        go(2);
        step(14);
        u_if.delay_sec = 4'd4;
        u_if.restart   = 1'b1;
        step();
        u_if.restart   = 1'b0;
        u_if.delay_sec = 4'd7;
        outs("rs.r", 0, 0, 1, 4);
        step(39);
        outs("rs.r39", 0, 0, 1, 1);
        step();
        outs("rs.r40", 1, 1, 0, 0);
        step(2);
        u_if.delay_sec = 4'd1;
        u_if.restart   = 1'b1;
        step();
        u_if.restart   = 1'b0;
        outs("rsd", 0, 0, 1, 1);
        step(9);
        chk("rsd.9.done", int'(u_if.done), 0);
        step();
        outs("rsd.10", 1, 1, 0, 0);

        // Zero delay, restart in DONE with zero delay, abort.
        go(0);
        outs("z.s", 1, 1, 0, 0);
        step();
        outs("z.s1", 1, 0, 0, 0);
        u_if.restart = 1'b1;
        step();
        u_if.restart = 1'b0;
        outs("z.rs", 1, 1, 0, 0);
        u_if.enable = 1'b0;
        step();
        outs("z.off", 0, 0, 0, 0);

        // Restart coinciding with the terminal tick.
        go(1);
        step(9);
        p0 = pulse_cnt;
        u_if.delay_sec = 4'd3;
        u_if.restart   = 1'b1;
        step();
        u_if.restart = 1'b0;
        outs("tt", 0, 0, 1, 3);
        step(2);
        chk("tt.npulse", pulse_cnt - p0, 0);

        // Abort during COUNT.
        step(3);
        u_if.enable = 1'b0;
        step();
        outs("abort", 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
